// File: rtl/md_pkg.sv
// md_pkg
// Shared definitions for the execute-stage multiply/divide unit:
//   - MD opcode encodings presented by the ID/EX register
//   - the iteration state machine encoding
//   - default operand width and the matching iteration-counter width
package md_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_RSVD  = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
// Iterative multiply/divide unit with architectural HI/LO, sitting right after
// the ID/EX register. Signed operands are reduced to magnitudes on acceptance,
// the core runs one bit per cycle on magnitudes, and a final FIX cycle applies
// the result signs and commits HI/LO. All state changes on the falling edge of
// clk, in step with the pipeline registers.
//
// Ports:
//   clk          pipeline clock (state updates on falling edge)
//   Reset        synchronous active-high reset
//   Start        MD-class instruction valid in EX
//   MD_op_in     MD opcode (see md_pkg::md_op_e)
//   Rs_val_in    dividend / multiplicand / MTHI-MTLO source
//   Rt_val_in    divisor / multiplier
//   Busy         high while an operation is in flight (hazard unit stalls)
//   Done         one-cycle pulse on result commit or divide-by-zero
//   Div_by_zero  one-cycle pulse with Done for DIV/DIVU by zero
//   HI_out       architectural HI
//   LO_out       architectural LO
module ex_muldiv_unit
  import md_pkg::*;
#(
  parameter int DATA_W = md_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [2:0]        MD_op_in,
  input  logic [DATA_W-1:0] Rs_val_in,
  input  logic [DATA_W-1:0] Rt_val_in,
  output logic              Busy,
  output logic              Done,
  output logic              Div_by_zero,
  output logic [DATA_W-1:0] HI_out,
  output logic [DATA_W-1:0] LO_out
);

  localparam int CW = $clog2(DATA_W + 1);

  md_state_e           state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  // Multiplicand magnitude during MUL, divisor magnitude during DIV.
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  // MUL: {partial product, remaining multiplier bits}.
  // DIV: {partial remainder, dividend bits shifting into quotient}.
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic                neg_lo_q, neg_lo_d;
  logic                neg_hi_q, neg_hi_d;
  logic                is_div_q, is_div_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;

  md_op_e              op;
  logic                signed_op;
  logic                rs_neg, rt_neg;
  logic [DATA_W-1:0]   rs_mag, rt_mag;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     div_shl;
  logic [DATA_W:0]     div_diff;
  logic [2*DATA_W-1:0] div_next;
  logic [2*DATA_W-1:0] prod_fixed;
  logic [DATA_W-1:0]   quo_fixed, rem_fixed;

  // Operand decode and magnitude extraction. Negating 0x80000000 yields
  // 0x80000000, which is the correct magnitude when read as unsigned.
  always_comb begin
    op        = md_op_e'(MD_op_in);
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    rs_neg    = signed_op && Rs_val_in[DATA_W-1];
    rt_neg    = signed_op && Rt_val_in[DATA_W-1];
    rs_mag    = rs_neg ? -Rs_val_in : Rs_val_in;
    rt_mag    = rt_neg ? -Rt_val_in : Rt_val_in;
  end

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole accumulator right.
  // The carry out of the add becomes the new MSB.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[DATA_W-1:1]}
                        : {1'b0, acc_q[2*DATA_W-1:1]};
  end

  // One restoring-division step: shift the next dividend bit into the
  // remainder (which may need one extra bit), subtract the divisor if it fits
  // and shift the resulting quotient bit into the low end.
  always_comb begin
    div_shl  = acc_q[2*DATA_W-1:DATA_W-1];
    div_diff = div_shl - {1'b0, opnd_q};
    if (div_shl >= {1'b0, opnd_q}) begin
      div_next = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    end else begin
      div_next = {div_shl[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
    end
  end

  // Sign correction applied in FIX; unsigned ops have both flags clear.
  always_comb begin
    prod_fixed = neg_lo_q ? -acc_q : acc_q;
    quo_fixed  = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    rem_fixed  = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
  end

  // Next-state logic: acceptance only in IDLE, iteration in MUL/DIV,
  // commit in FIX. Done and Div_by_zero are pulses and default low.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    is_div_d = is_div_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          case (op)
            MD_MTHI: hi_d = Rs_val_in;
            MD_MTLO: lo_d = Rs_val_in;
            MD_MULT, MD_MULTU: begin
              opnd_d   = rs_mag;
              acc_d    = {{DATA_W{1'b0}}, rt_mag};
              neg_lo_d = rs_neg ^ rt_neg;
              neg_hi_d = 1'b0;
              is_div_d = 1'b0;
              cnt_d    = CW'(DATA_W);
              state_d  = MUL;
            end
            MD_DIV, MD_DIVU: begin
              if (Rt_val_in == '0) begin
                done_d = 1'b1;
                dbz_d  = 1'b1;
              end else begin
                opnd_d   = rt_mag;
                acc_d    = {{DATA_W{1'b0}}, rs_mag};
                neg_lo_d = rs_neg ^ rt_neg;
                neg_hi_d = rs_neg;
                is_div_d = 1'b1;
                cnt_d    = CW'(DATA_W);
                state_d  = DIV;
              end
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = rem_fixed;
          lo_d = quo_fixed;
        end else begin
          hi_d = prod_fixed[2*DATA_W-1:DATA_W];
          lo_d = prod_fixed[DATA_W-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State register on the falling edge; Reset discards any partial result.
  always_ff @(negedge clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      is_div_q <= is_div_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Div_by_zero = dbz_q;
  assign HI_out      = hi_q;
  assign LO_out      = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit
// Directed bench for ex_muldiv_unit. The DUT updates on the falling edge, so
// inputs are driven and outputs sampled on the rising edge.
module tb_ex_muldiv_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.DATA_W(32)) dut (
    .clk        (clk),
    .Reset      (reset),
    .Start      (start),
    .MD_op_in   (op),
    .Rs_val_in  (rs),
    .Rt_val_in  (rt),
    .Busy       (busy),
    .Done       (done),
    .Div_by_zero(dbz),
    .HI_out     (hi),
    .LO_out     (lo)
  );

  // Present one instruction across exactly one falling edge; returns at the
  // rising edge right after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk);
    start = 1'b0; op = 3'b000; rs = '0; rt = '0;
  endtask

  // Wait (bounded) until Busy drops; cycles = number of Busy-high samples.
  task automatic wait_idle(input string name, output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(posedge clk);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_idle busy=%b want 0", name, busy);
    end
  endtask

  task automatic test_reset;
    // Reset asserted together with a valid Start: reset must win.
    reset = 1'b1; start = 1'b1; op = MD_MULT; rs = 32'd3; rt = 32'd4;
    repeat (2) @(posedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    total++; if (dbz !== 1'b0) begin bad++; $display("[TB] FAIL reset_dbz got=%b want=0", dbz); end
    total++; if (hi !== 32'h0) begin bad++; $display("[TB] FAIL reset_hi got=%h want=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("[TB] FAIL reset_lo got=%h want=0", lo); end
    reset = 1'b0; start = 1'b0; op = 3'b000; rs = '0; rt = '0;
  endtask

  task automatic test_mult_signed;
    int cyc;
    issue(MD_MULT, 32'd7, 32'hFFFF_FFFD);
    wait_idle("mult", cyc);
    total++; if (cyc != 33) begin bad++; $display("[TB] FAIL mult_busy_cycles got=%0d want=33", cyc); end
    total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL mult_done got=%b want=1", done); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL mult_hi got=%h want=ffffffff", hi); end
    total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("[TB] FAIL mult_lo got=%h want=ffffffeb", lo); end
    total++; if (dbz !== 1'b0) begin bad++; $display("[TB] FAIL mult_dbz got=%b want=0", dbz); end
    @(posedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL mult_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_multu;
    int cyc = 0;
    bit changed = 0;
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    while (busy === 1'b1 && cyc < 100) begin
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) changed = 1;
      cyc++;
      @(posedge clk);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL multu_idle busy=%b want 0", busy); end
    total++; if (changed) begin bad++; $display("[TB] FAIL multu_hilo_hold got=changed want=held"); end
    total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("[TB] FAIL multu_hi got=%h want=fffffffe", hi); end
    total++; if (lo !== 32'h0000_0001) begin bad++; $display("[TB] FAIL multu_lo got=%h want=00000001", lo); end
    total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL multu_done got=%b want=1", done); end
  endtask

  task automatic test_div;
    logic [2:0]  v_op [4] = '{MD_DIV, MD_DIVU, MD_DIV, MD_DIV};
    logic [31:0] v_a  [4] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7};
    logic [31:0] v_b  [4] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] v_lo [4] = '{32'hFFFF_FFFD, 32'h0000_000E, 32'h8000_0000, 32'hFFFF_FFFD};
    logic [31:0] v_hi [4] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000, 32'h0000_0001};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      issue(v_op[i], v_a[i], v_b[i]);
      wait_idle("div", cyc);
      total++; if (cyc != 33) begin bad++; $display("[TB] FAIL div%0d_cycles got=%0d want=33", i, cyc); end
      total++; if (lo !== v_lo[i]) begin bad++; $display("[TB] FAIL div%0d_lo got=%h want=%h", i, lo, v_lo[i]); end
      total++; if (hi !== v_hi[i]) begin bad++; $display("[TB] FAIL div%0d_hi got=%h want=%h", i, hi, v_hi[i]); end
      total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL div%0d_done got=%b want=1", i, done); end
    end
  endtask

  task automatic test_div_by_zero;
    issue(MD_MTHI, 32'h11, 32'h0);
    issue(MD_MTLO, 32'h22, 32'h0);
    issue(MD_DIV, 32'd5, 32'd0);
    total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL dbz_done got=%b want=1", done); end
    total++; if (dbz !== 1'b1) begin bad++; $display("[TB] FAIL dbz_flag got=%b want=1", dbz); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL dbz_busy got=%b want=0", busy); end
    total++; if (hi !== 32'h11) begin bad++; $display("[TB] FAIL dbz_hi got=%h want=11", hi); end
    total++; if (lo !== 32'h22) begin bad++; $display("[TB] FAIL dbz_lo got=%h want=22", lo); end
    @(posedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL dbz_done_pulse got=%b want=0", done); end
    total++; if (dbz !== 1'b0) begin bad++; $display("[TB] FAIL dbz_flag_pulse got=%b want=0", dbz); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL dbz_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_mthi_mtlo;
    @(posedge clk);
    start = 1'b1; op = MD_MTHI; rs = 32'h1234_5678;
    @(posedge clk);
    op = MD_MTLO; rs = 32'h9ABC_DEF0;
    total++; if (hi !== 32'h1234_5678) begin bad++; $display("[TB] FAIL mthi_hi got=%h want=12345678", hi); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mthi_busy got=%b want=0", busy); end
    @(posedge clk);
    start = 1'b0; op = 3'b000; rs = '0;
    total++; if (lo !== 32'h9ABC_DEF0) begin bad++; $display("[TB] FAIL mtlo_lo got=%h want=9abcdef0", lo); end
    total++; if (hi !== 32'h1234_5678) begin bad++; $display("[TB] FAIL mtlo_hi got=%h want=12345678", hi); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mtlo_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL mtlo_done got=%b want=0", done); end
  endtask

  task automatic test_start_while_busy;
    int cyc;
    issue(MD_MULT, 32'd6, 32'd7);
    repeat (5) @(posedge clk);
    start = 1'b1; op = MD_MULT; rs = 32'd100; rt = 32'd100;
    @(posedge clk);
    start = 1'b0; op = 3'b000; rs = '0; rt = '0;
    wait_idle("busy_start", cyc);
    total++; if (lo !== 32'd42) begin bad++; $display("[TB] FAIL busy_start_lo got=%h want=2a", lo); end
    total++; if (hi !== 32'd0) begin bad++; $display("[TB] FAIL busy_start_hi got=%h want=0", hi); end
    total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL busy_start_done got=%b want=1", done); end
    @(posedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_start_ignored got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    issue(MD_MULT, 32'd7, 32'd5);
    repeat (9) @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (hi !== 32'h0) begin bad++; $display("[TB] FAIL rstmid_hi got=%h want=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("[TB] FAIL rstmid_lo got=%h want=0", lo); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_done got=%b want=0", done); end
    issue(MD_MULT, 32'd3, 32'd4);
    wait_idle("rstmid_mult", cyc);
    total++; if (lo !== 32'd12) begin bad++; $display("[TB] FAIL rstmid_lo12 got=%h want=c", lo); end
    total++; if (hi !== 32'd0) begin bad++; $display("[TB] FAIL rstmid_hi0 got=%h want=0", hi); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue(MD_MULTU, 32'd2, 32'd3);
    wait_idle("b2b_first", cyc);
    total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL b2b_done got=%b want=1", done); end
    // Start during the Done cycle must be accepted.
    start = 1'b1; op = MD_DIVU; rs = 32'd100; rt = 32'd7;
    @(posedge clk);
    start = 1'b0; op = 3'b000; rs = '0; rt = '0;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_accept got=%b want=1", busy); end
    total++; if (lo !== 32'd6) begin bad++; $display("[TB] FAIL b2b_first_lo got=%h want=6", lo); end
    wait_idle("b2b_second", cyc);
    total++; if (lo !== 32'h0000_000E) begin bad++; $display("[TB] FAIL b2b_lo got=%h want=e", lo); end
    total++; if (hi !== 32'h0000_0002) begin bad++; $display("[TB] FAIL b2b_hi got=%h want=2", hi); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'b000; rs = '0; rt = '0;
    test_reset();
    test_mult_signed();
    test_multu();
    test_div();
    test_div_by_zero();
    test_mthi_mtlo();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
